// File: rtl/vector_pkg.sv
// Shared constants and types for the lane-parallel vector divider.
package vector_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANES      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [DEF_LANES-1:0][DEF_DATA_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/divider_lane.sv
// One lane of the restoring divider: sign/magnitude capture, shift-subtract
// iteration and final sign fix-up, stepped by strobes from the top-level FSM.
module divider_lane
  import vector_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  finish,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_zero
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic         a_neg_s, b_neg_s, zero_s, ovf_s, ge_s;
  logic [W-1:0] a_mag_s, diff_s, rem_nx_s, dq_nx_s, q_s, r_s;
  logic [W:0]   b_mag_s, rem_sh_s;

  logic [W-1:0] rem_r, dq_r, dvd_r;
  logic [W:0]   dvs_r;
  logic         a_neg_r, b_neg_r, zero_r, ovf_r;

  // Operand sign and magnitude capture; divisor magnitude needs W+1 bits
  always_comb begin
    a_neg_s = signed_mode & dividend[W-1];
    b_neg_s = signed_mode & divisor[W-1];
    a_mag_s = a_neg_s ? (~dividend + W'(1)) : dividend;
    b_mag_s = b_neg_s ? ({1'b0, ~divisor} + (W+1)'(1)) : {1'b0, divisor};
    zero_s  = (divisor == {W{1'b0}});
    ovf_s   = signed_mode & (dividend == MOST_NEG) & (divisor == {W{1'b1}});
  end

  // One restoring step; when the subtract succeeds the true difference is
  // below the divisor, so its low W bits are exact
  always_comb begin
    rem_sh_s = {rem_r, dq_r[W-1]};
    ge_s     = (rem_sh_s >= dvs_r);
    diff_s   = rem_sh_s[W-1:0] - dvs_r[W-1:0];
    rem_nx_s = ge_s ? diff_s : rem_sh_s[W-1:0];
    dq_nx_s  = {dq_r[W-2:0], ge_s};
  end

  // Final result from the last step's values, with the special cases overriding
  always_comb begin
    if (zero_r) begin
      q_s = {W{1'b1}};
      r_s = dvd_r;
    end else if (ovf_r) begin
      q_s = MOST_NEG;
      r_s = {W{1'b0}};
    end else begin
      q_s = (a_neg_r ^ b_neg_r) ? (~dq_nx_s + W'(1)) : dq_nx_s;
      r_s = a_neg_r ? (~rem_nx_s + W'(1)) : rem_nx_s;
    end
  end

  // Iteration state and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r     <= {W{1'b0}};
      dq_r      <= {W{1'b0}};
      dvd_r     <= {W{1'b0}};
      dvs_r     <= {(W+1){1'b0}};
      a_neg_r   <= 1'b0;
      b_neg_r   <= 1'b0;
      zero_r    <= 1'b0;
      ovf_r     <= 1'b0;
      quotient  <= {W{1'b0}};
      remainder <= {W{1'b0}};
      div_zero  <= 1'b0;
    end else begin
      if (load) begin
        rem_r   <= {W{1'b0}};
        dq_r    <= a_mag_s;
        dvd_r   <= dividend;
        dvs_r   <= b_mag_s;
        a_neg_r <= a_neg_s;
        b_neg_r <= b_neg_s;
        zero_r  <= zero_s;
        ovf_r   <= ovf_s;
      end else if (step) begin
        rem_r <= rem_nx_s;
        dq_r  <= dq_nx_s;
      end
      if (finish) begin
        quotient  <= q_s;
        remainder <= r_s;
        div_zero  <= zero_r;
      end
    end
  end

endmodule

// File: rtl/vector_divider.sv
// Lane-parallel multi-cycle integer divider with start/busy/done handshake;
// one quotient bit per cycle in every lane.
module vector_divider
  import vector_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             signed_mode,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] operand1,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] operand2,
  output logic                             ready,
  output logic                             busy,
  output logic                             done,
  output logic [LANES-1:0][DATA_WIDTH-1:0] quotient,
  output logic [LANES-1:0][DATA_WIDTH-1:0] remainder,
  output logic [LANES-1:0]                 div_zero
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  state_e        state_r;
  logic [CW-1:0] cnt_r;
  logic          load_s, step_s, finish_s;

  // Shared lane strobes
  always_comb begin
    load_s   = start & ready;
    step_s   = busy;
    finish_s = busy & (cnt_r == CNT_LAST);
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= RUN;
            cnt_r   <= {CW{1'b0}};
            ready   <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= DONE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
          ready   <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    divider_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .load       (load_s),
      .step       (step_s),
      .finish     (finish_s),
      .signed_mode(signed_mode),
      .dividend   (operand1[i]),
      .divisor    (operand2[i]),
      .quotient   (quotient[i]),
      .remainder  (remainder[i]),
      .div_zero   (div_zero[i])
    );
  end

endmodule

// File: tb/tb_vector_divider.sv
// Scoreboard bench for vector_divider: random and directed operations are
// checked against an arithmetic reference model by a decoupled monitor.
module tb_vector_divider;
  import vector_pkg::*;

  localparam int W = 8;
  localparam int L = 8;
  localparam int SA[L] = '{-7, 7, -7, -128, -128, 127, 0, -1};
  localparam int SB[L] = '{2, -2, -2, -1, 1, -128, 5, 3};

  logic          clk = 1'b0;
  logic          rst, start, signed_mode;
  lane_vec_t     operand1, operand2, quotient, remainder;
  logic          ready, busy, done;
  logic [L-1:0]  div_zero;

  typedef struct {
    lane_vec_t    q;
    lane_vec_t    r;
    logic [L-1:0] dz;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  vector_divider #(.DATA_WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .operand1(operand1), .operand2(operand2),
    .ready(ready), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: plain integer division with the special cases applied up front
  function automatic exp_t model(input lane_vec_t a, input lane_vec_t b, input bit sm, input int acc);
    exp_t e;
    e.acc = acc;
    for (int i = 0; i < L; i++) begin
      int x, y, q, r;
      if (b[i] == 8'h00) begin
        e.q[i] = 8'hFF; e.r[i] = a[i]; e.dz[i] = 1'b1;
      end else begin
        e.dz[i] = 1'b0;
        if (sm) begin x = int'($signed(a[i])); y = int'($signed(b[i])); end
        else    begin x = int'(a[i]);          y = int'(b[i]);          end
        if (sm && x == -128 && y == -1) begin q = -128; r = 0; end
        else begin q = x / y; r = x % y; end
        e.q[i] = q[7:0];
        e.r[i] = r[7:0];
      end
    end
    return e;
  endfunction

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h01;
      default: return 8'($urandom());
    endcase
  endfunction

  function automatic lane_vec_t rnd_vec();
    lane_vec_t v;
    for (int i = 0; i < L; i++) v[i] = rnd_byte();
    return v;
  endfunction

  // Garbage on the inputs while the divider is busy
  task automatic filler(input bit hold);
    operand1    = rnd_vec();
    operand2    = rnd_vec();
    signed_mode = 1'($urandom_range(0, 1));
    start       = hold ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic send(input lane_vec_t a, input lane_vec_t b, input bit sm, input bit hold);
    int n = 0;
    while (!ready && n < 40) begin filler(hold); @(negedge clk); n++; end
    chk("ready_wait", 64'(ready), 64'(1));
    if (ready) begin
      operand1 = a; operand2 = b; signed_mode = sm; start = 1'b1;
      sb.push_back(model(a, b, sm, cyc));
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!ready && n < 40) begin filler(1'b0); @(negedge clk); n++; end
    start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk("drain", 64'(sb.size()), 64'(0));
  endtask

  // Monitor: handshake timing every cycle, results on done
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        bit   be, de;
        exp_t e;
        while (sb.size() > 0 && cyc > sb[0].acc + 9) begin
          n_cmp++; n_bad++;
          $display("FAIL done_missing: no done for op accepted at cycle %0d, now %0d", sb[0].acc, cyc);
          void'(sb.pop_front());
        end
        be = sb.size() > 0 && cyc >= sb[0].acc + 1 && cyc <= sb[0].acc + 8;
        de = sb.size() > 0 && cyc == sb[0].acc + 9;
        chk("busy",  64'(busy),  64'(be));
        chk("ready", 64'(ready), 64'(!be));
        chk("done",  64'(done),  64'(de));
        if (done && de) begin
          e = sb.pop_front();
          chk("quotient",  quotient,  e.q);
          chk("remainder", remainder, e.r);
          chk("div_zero",  64'(div_zero), 64'(e.dz));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    lane_vec_t a, b;
    int        acc;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0;
    operand1 = '0; operand2 = '0;
    #1;
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_busy",  64'(busy),  64'(0));
    chk("rst_done",  64'(done),  64'(0));
    chk("rst_q",     quotient,   64'(0));
    chk("rst_r",     remainder,  64'(0));
    chk("rst_dz",    64'(div_zero), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned basic
    for (int i = 0; i < L; i++) begin a[i] = 8'(100 + i); b[i] = 8'd7; end
    send(a, b, 1'b0, 1'b0);
    drain();
    chk("basic_q0", 64'(quotient[0]),  64'(14));
    chk("basic_r0", 64'(remainder[0]), 64'(2));
    chk("basic_q7", 64'(quotient[7]),  64'(15));
    chk("basic_r7", 64'(remainder[7]), 64'(2));

    // Signed mixed, including the overflow lane
    for (int i = 0; i < L; i++) begin a[i] = 8'(SA[i]); b[i] = 8'(SB[i]); end
    send(a, b, 1'b1, 1'b0);
    drain();
    chk("signed_q3", 64'(quotient[3]),  64'(8'h80));
    chk("signed_r7", 64'(remainder[7]), 64'(8'hFF));

    // Divide by zero in lane 2 only
    for (int i = 0; i < L; i++) begin a[i] = 8'($urandom()); b[i] = 8'($urandom_range(1, 255)); end
    a[2] = 8'h5A; b[2] = 8'h00;
    send(a, b, 1'b0, 1'b0);
    drain();
    chk("dz_flags", 64'(div_zero), 64'(8'b0000_0100));
    chk("dz_q2",    64'(quotient[2]), 64'(8'hFF));

    // start held high: second op accepted in the DONE cycle
    send(rnd_vec(), rnd_vec(), 1'b0, 1'b1);
    send(rnd_vec(), rnd_vec(), 1'b1, 1'b1);
    drain();

    // Reset in cycle 4 of RUN aborts the operation
    send(rnd_vec(), rnd_vec(), 1'b1, 1'b0);
    acc = sb[$].acc;
    while (cyc < acc + 4) begin filler(1'b0); @(negedge clk); end
    rst = 1'b1; start = 1'b0;
    sb.delete();
    #1;
    chk("abort_ready", 64'(ready), 64'(1));
    chk("abort_busy",  64'(busy),  64'(0));
    chk("abort_done",  64'(done),  64'(0));
    chk("abort_q",     quotient,   64'(0));
    chk("abort_r",     remainder,  64'(0));
    chk("abort_dz",    64'(div_zero), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(rnd_vec(), rnd_vec(), 1'b0, 1'b0);
    drain();

    // Random operations with mixed holds and idle gaps
    for (int k = 0; k < 40; k++) begin
      send(rnd_vec(), rnd_vec(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        drain();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
